// File: rtl/noc_axilite_resp_bridge_pkg.sv
// noc_axilite_resp_bridge_pkg
//   Shared definitions for the AXI-lite <-> Piton NoC bridges:
//   - header field macros and message type codes (macros so the request
//     bridge can use the same field selects)
//   - bus width macros
//   - FSM state encoding, AXI response codes, header classification helper
// No ports (package).

`ifndef NOC_AXILITE_BRIDGE_DEFS
`define NOC_AXILITE_BRIDGE_DEFS
`define NOC_DATA_WIDTH           64
`define C_M_AXI_LITE_DATA_WIDTH  32
`define C_M_AXI_LITE_RESP_WIDTH  2
`define MSG_LENGTH               29:22
`define MSG_TYPE                 21:14
`define MSG_TYPE_LOAD_MEM_ACK    8'd24
`define MSG_TYPE_STORE_MEM_ACK   8'd25
`endif

package noc_axilite_resp_bridge_pkg;

  localparam int NOC_DATA_W  = `NOC_DATA_WIDTH;
  localparam int AXI_DATA_W  = `C_M_AXI_LITE_DATA_WIDTH;
  localparam int AXI_RESP_W  = `C_M_AXI_LITE_RESP_WIDTH;
  localparam int MSG_LEN_LSB  = 22;
  localparam int MSG_TYPE_LSB = 14;

  localparam logic [7:0] LOAD_MEM_ACK_T  = `MSG_TYPE_LOAD_MEM_ACK;
  localparam logic [7:0] STORE_MEM_ACK_T = `MSG_TYPE_STORE_MEM_ACK;

  localparam logic [AXI_RESP_W-1:0] RESP_OKAY   = 2'b00;
  localparam logic [AXI_RESP_W-1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    ST_HDR   = 3'd0,
    ST_DATA  = 3'd1,
    ST_DRAIN = 3'd2,
    ST_RSP_R = 3'd3,
    ST_RSP_B = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    HDR_LOAD  = 2'd0,
    HDR_STORE = 2'd1,
    HDR_OTHER = 2'd2
  } hdr_kind_e;

  function automatic hdr_kind_e decode_kind(input logic [7:0] msg_type);
    if (msg_type == LOAD_MEM_ACK_T)       return HDR_LOAD;
    else if (msg_type == STORE_MEM_ACK_T) return HDR_STORE;
    else                                  return HDR_OTHER;
  endfunction

endpackage

// File: rtl/noc_axilite_resp_bridge.sv
// noc_axilite_resp_bridge
//   Accepts Piton NoC response packets from the memory splitter and returns
//   them to the AXI-lite master as a single R (load ack) or B (store ack)
//   response. One response in flight; no buffering.
//
//   State | meaning
//   HDR   | waiting for a header flit
//   DATA  | receiving load payload; first flit becomes rdata
//   DRAIN | discarding payload (store ack payload or unknown packet)
//   RSP_R | presenting read response until rready
//   RSP_B | presenting write response until bready
//
// Ports
//   clk, rst_n                       clock, async active-low reset
//   splitter_bridge_val/_data        NoC flit in
//   bridge_splitter_rdy              flit accept (decode of state only)
//   m_axi_rdata/rresp/rvalid/rready  AXI-lite R channel
//   m_axi_bresp/bvalid/bready        AXI-lite B channel
//   resp_drop_cnt                    saturating count of discarded packets

module noc_axilite_resp_bridge
  import noc_axilite_resp_bridge_pkg::*;
#(
  parameter int DROP_CNT_WIDTH = 8
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                splitter_bridge_val,
  input  logic [`NOC_DATA_WIDTH-1:0]          splitter_bridge_data,
  output logic                                bridge_splitter_rdy,
  output logic [`C_M_AXI_LITE_DATA_WIDTH-1:0] m_axi_rdata,
  output logic [`C_M_AXI_LITE_RESP_WIDTH-1:0] m_axi_rresp,
  output logic                                m_axi_rvalid,
  input  logic                                m_axi_rready,
  output logic [`C_M_AXI_LITE_RESP_WIDTH-1:0] m_axi_bresp,
  output logic                                m_axi_bvalid,
  input  logic                                m_axi_bready,
  output logic [DROP_CNT_WIDTH-1:0]           resp_drop_cnt
);

  state_e                                state_q, state_d;
  logic [7:0]                            rem_q, rem_d;
  logic                                  first_pend_q, first_pend_d;
  logic                                  is_store_q, is_store_d;
  logic [`C_M_AXI_LITE_DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic [`C_M_AXI_LITE_RESP_WIDTH-1:0]   rresp_q, rresp_d;
  logic [`C_M_AXI_LITE_RESP_WIDTH-1:0]   bresp_q, bresp_d;
  logic [DROP_CNT_WIDTH-1:0]             drop_cnt_q, drop_cnt_d;

  logic       xfer;
  logic [7:0] hdr_len;
  logic [7:0] hdr_type;
  logic       unused_data_bits;

  assign hdr_len  = splitter_bridge_data[`MSG_LENGTH];
  assign hdr_type = splitter_bridge_data[`MSG_TYPE];
  assign unused_data_bits = ^splitter_bridge_data[`NOC_DATA_WIDTH-1:`C_M_AXI_LITE_DATA_WIDTH];

  // rdy depends only on registered state, never on val or the AXI readies
  assign bridge_splitter_rdy = (state_q == ST_HDR) || (state_q == ST_DATA) ||
                               (state_q == ST_DRAIN);
  assign xfer = splitter_bridge_val && bridge_splitter_rdy;

  always_comb begin
    state_d      = state_q;
    rem_d        = rem_q;
    first_pend_d = first_pend_q;
    is_store_d   = is_store_q;
    rdata_d      = rdata_q;
    rresp_d      = rresp_q;
    bresp_d      = bresp_q;
    drop_cnt_d   = drop_cnt_q;

    case (state_q)
      ST_HDR: begin
        if (xfer) begin
          case (decode_kind(hdr_type))
            HDR_LOAD: begin
              if (hdr_len != 8'd0) begin
                state_d      = ST_DATA;
                rem_d        = hdr_len;
                first_pend_d = 1'b1;
              end else begin
                // load ack with no data: report an error rather than stale data
                rdata_d = '0;
                rresp_d = RESP_SLVERR;
                state_d = ST_RSP_R;
              end
            end
            HDR_STORE: begin
              bresp_d    = RESP_OKAY;
              is_store_d = 1'b1;
              if (hdr_len != 8'd0) begin
                state_d = ST_DRAIN;
                rem_d   = hdr_len;
              end else begin
                state_d = ST_RSP_B;
              end
            end
            default: begin
              if (drop_cnt_q != {DROP_CNT_WIDTH{1'b1}})
                drop_cnt_d = drop_cnt_q + 1'b1;
              is_store_d = 1'b0;
              if (hdr_len != 8'd0) begin
                state_d = ST_DRAIN;
                rem_d   = hdr_len;
              end
            end
          endcase
        end
      end

      ST_DATA: begin
        if (xfer) begin
          if (first_pend_q) begin
            rdata_d      = splitter_bridge_data[`C_M_AXI_LITE_DATA_WIDTH-1:0];
            rresp_d      = RESP_OKAY;
            first_pend_d = 1'b0;
          end
          rem_d = rem_q - 8'd1;
          // compare before decrement so len=255 never wraps into a false end
          if (rem_q == 8'd1) state_d = ST_RSP_R;
        end
      end

      ST_DRAIN: begin
        if (xfer) begin
          rem_d = rem_q - 8'd1;
          if (rem_q == 8'd1) state_d = is_store_q ? ST_RSP_B : ST_HDR;
        end
      end

      ST_RSP_R: begin
        if (m_axi_rready) state_d = ST_HDR;
      end

      ST_RSP_B: begin
        if (m_axi_bready) state_d = ST_HDR;
      end

      default: state_d = ST_HDR;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_HDR;
      rem_q        <= '0;
      first_pend_q <= 1'b0;
      is_store_q   <= 1'b0;
      rdata_q      <= '0;
      rresp_q      <= '0;
      bresp_q      <= '0;
      drop_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      rem_q        <= rem_d;
      first_pend_q <= first_pend_d;
      is_store_q   <= is_store_d;
      rdata_q      <= rdata_d;
      rresp_q      <= rresp_d;
      bresp_q      <= bresp_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

  assign m_axi_rvalid  = (state_q == ST_RSP_R);
  assign m_axi_bvalid  = (state_q == ST_RSP_B);
  assign m_axi_rdata   = rdata_q;
  assign m_axi_rresp   = rresp_q;
  assign m_axi_bresp   = bresp_q;
  assign resp_drop_cnt = drop_cnt_q;

endmodule
